alu_iterative: RTL
==================

Name: alu_iterative

Overview:
- Parametrised, handshaked successor to the datapath ALU.
- Keeps the existing 4-bit op encoding for single-cycle ops and adds multiply, multiply-high and signed/unsigned divide/remainder, executed iteratively (one bit per clock).
- Sits in the execute stage; the pipeline stalls on in_ready low.
- Operands and result are registered, so the block is a clean pipeline boundary.

Parameters:
WIDTH, 32, operand/result width; must be a power of 2, >= 8
SHW, $clog2(WIDTH), shift-amount bits taken from operand_1 (derived; do not override)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  request valid
in_ready  output  1  block can accept a request
ALU_Sel  input  4  operation select
operand_0  input  WIDTH  first operand / dividend / multiplicand
operand_1  input  WIDTH  second operand / divisor / multiplier / shift amount
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  registered result

Behaviour:
- Ops, single-cycle class:
  - 0000 ADD; 0001 SUB; 0010 AND; 0011 OR; 0100 XOR.
  - 0101 SLTU: unsigned less-than, result 1/0.
  - 0110 SLL; 0111 SRL; 1000 SRA. All shifts use operand_1[SHW-1:0].
  - 1001 SLT: signed less-than, result 1/0.
- Ops, iterative class:
  - 1010 MUL: low WIDTH bits of the product.
  - 1011 MULHU: high WIDTH bits of the unsigned 2*WIDTH product.
  - 1100 DIV: signed quotient, truncates toward zero.
  - 1101 DIVU: unsigned quotient.
  - 1110 REM: signed remainder; sign follows the dividend.
  - 1111 REMU: unsigned remainder.
- States:
  - IDLE: in_ready=1.
  - BUSY: iterating.
  - DONE: out_valid=1, holding result.
- Accept: in_valid && in_ready on an edge latches ALU_Sel and both operands.
- Transitions:
  - Single-cycle op accepted: IDLE -> DONE. Result is valid in the cycle after accept (latency 1).
  - Iterative op accepted: IDLE -> BUSY. A counter runs WIDTH cycles. MUL/MULHU use shift-add; DIV* use restoring division on absolute values.
  - BUSY -> DONE after WIDTH iterations. Signed fixup of the result happens on that transition. out_valid rises exactly WIDTH+1 cycles after accept.
  - DONE -> IDLE on out_ready. result and out_valid are held stable while out_ready=0.
- in_ready=0 in BUSY and DONE: no back-to-back acceptance and no overlap (throughput one op per completion plus one cycle).
- Inputs are ignored unless accepted. Changing operands during BUSY has no effect.
- Divide by zero: no early exit; takes the full WIDTH+1 latency.
  - DIV/DIVU: all-ones.
  - REM/REMU: dividend unchanged.
- Signed overflow (dividend = most-negative value, divisor = -1):
  - DIV: most-negative value.
  - REM: 0.
- All arithmetic wraps modulo 2^WIDTH; no flags are produced.
- Reset:
  - Values: state IDLE, in_ready=1 after reset, out_valid=0, result=0, counter=0.
  - Reset wins over any simultaneous in_valid or out_ready.
  - Reset mid-BUSY or in DONE abandons the operation: no out_valid pulse, result cleared.
- No undefined opcodes exist. All 16 codes are defined.

Test Plan:
- Single-cycle ops, WIDTH=32:
  - ADD 0x7FFFFFFF+1 -> 0x80000000, out_valid exactly 1 cycle after accept.
  - SUB 0-1 -> 0xFFFFFFFF.
  - SRA 0x80000000 by operand_1=0x21 (uses 1) -> 0xC0000000.
  - SLT 0xFFFFFFFF<1 -> 1.
  - SLTU 0xFFFFFFFF<1 -> 0.
- Multiply, WIDTH=32:
  - MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001.
  - MULHU of the same operands -> 0xFFFFFFFE.
  - out_valid exactly 33 cycles after accept; in_ready=0 throughout.
- Signed divide/remainder:
  - DIV -7/2 -> -3 (0xFFFFFFFD); REM -7/2 -> -1.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- Divide by zero:
  - DIVU 5/0 -> 0xFFFFFFFF; REM 5/0 -> 5; latency still 33 cycles.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after DONE: result and out_valid stay stable, and in_valid pulses are not accepted.
  - Then out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-op:
  - Assert rst at iteration 15 of a DIV: next cycle state IDLE, out_valid=0, result=0.
  - A new ADD issued afterwards completes correctly.
- Parametrisation:
  - WIDTH=8: MUL 0x10*0x10 -> 0x00; MULHU of the same operands -> 0x01.
  - SLL by 9 (uses 1) doubles the operand.
  - Iterative latency is 9 cycles.

Source files
------------

// File: rtl/alu_iterative.sv
// Handshaked execute-stage ALU: single-cycle logic/arith ops plus iterative
// shift-add multiply and restoring divide, one bit per clock.
module alu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       ALU_Sel,
    input  logic [WIDTH-1:0] operand_0,
    input  logic [WIDTH-1:0] operand_1,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result
);
    localparam int SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    typedef enum logic [3:0] {
        OP_ADD   = 4'b0000, OP_SUB   = 4'b0001, OP_AND  = 4'b0010, OP_OR   = 4'b0011,
        OP_XOR   = 4'b0100, OP_SLTU  = 4'b0101, OP_SLL  = 4'b0110, OP_SRL  = 4'b0111,
        OP_SRA   = 4'b1000, OP_SLT   = 4'b1001, OP_MUL  = 4'b1010, OP_MULHU = 4'b1011,
        OP_DIV   = 4'b1100, OP_DIVU  = 4'b1101, OP_REM  = 4'b1110, OP_REMU = 4'b1111
    } op_e;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] acc_q, acc_d;     // product high half / partial remainder
    logic [WIDTH-1:0] qr_q, qr_d;       // multiplier+product low half / dividend+quotient
    logic [WIDTH-1:0] dvs_q, dvs_d;     // multiplicand / divisor magnitude
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] result_q, result_d;

    op_e              sel;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] single_res;
    logic             sel_iter, sel_mul, sel_signed;
    logic [WIDTH-1:0] abs_0, abs_1;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic [WIDTH-1:0] acc_nx, qr_nx;

    assign sel       = op_e'(ALU_Sel);
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        shamt      = operand_1[SHW-1:0];
        single_res = '0;
        case (sel)
            OP_ADD:  single_res = operand_0 + operand_1;
            OP_SUB:  single_res = operand_0 - operand_1;
            OP_AND:  single_res = operand_0 & operand_1;
            OP_OR:   single_res = operand_0 | operand_1;
            OP_XOR:  single_res = operand_0 ^ operand_1;
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (operand_0 < operand_1)};
            OP_SLL:  single_res = operand_0 << shamt;
            OP_SRL:  single_res = operand_0 >> shamt;
            OP_SRA:  single_res = $signed(operand_0) >>> shamt;
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(operand_0) < $signed(operand_1))};
            default: single_res = '0;
        endcase

        sel_iter   = (sel >= OP_MUL);
        sel_mul    = (sel == OP_MUL) || (sel == OP_MULHU);
        sel_signed = (sel == OP_DIV) || (sel == OP_REM);
        abs_0      = (sel_signed && operand_0[WIDTH-1]) ? -operand_0 : operand_0;
        abs_1      = (sel_signed && operand_1[WIDTH-1]) ? -operand_1 : operand_1;

        mul_sum   = {1'b0, acc_q} + (qr_q[0] ? {1'b0, dvs_q} : '0);
        div_trial = {acc_q, qr_q[WIDTH-1]} - {1'b0, dvs_q};
        if ((op_q == OP_MUL) || (op_q == OP_MULHU)) begin
            acc_nx = mul_sum[WIDTH:1];
            qr_nx  = {mul_sum[0], qr_q[WIDTH-1:1]};
        end else if (!div_trial[WIDTH]) begin
            acc_nx = div_trial[WIDTH-1:0];
            qr_nx  = {qr_q[WIDTH-2:0], 1'b1};
        end else begin
            acc_nx = {acc_q[WIDTH-2:0], qr_q[WIDTH-1]};
            qr_nx  = {qr_q[WIDTH-2:0], 1'b0};
        end

        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        qr_d     = qr_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    op_d  = sel;
                    cnt_d = '0;
                    if (!sel_iter) begin
                        result_d = single_res;
                        state_d  = DONE;
                    end else begin
                        state_d = BUSY;
                        acc_d   = '0;
                        if (sel_mul) begin
                            qr_d    = operand_1;
                            dvs_d   = operand_0;
                            q_neg_d = 1'b0;
                            r_neg_d = 1'b0;
                        end else begin
                            qr_d    = abs_0;
                            dvs_d   = abs_1;
                            // Divide by zero keeps the all-ones quotient unsigned-looking.
                            q_neg_d = sel_signed && (operand_0[WIDTH-1] ^ operand_1[WIDTH-1])
                                      && (operand_1 != '0);
                            r_neg_d = sel_signed && operand_0[WIDTH-1];
                        end
                    end
                end
            end
            BUSY: begin
                acc_d = acc_nx;
                qr_d  = qr_nx;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH-1)) begin
                    state_d = DONE;
                    cnt_d   = '0;
                    case (op_q)
                        OP_MUL:          result_d = qr_nx;
                        OP_MULHU:        result_d = acc_nx;
                        OP_DIV, OP_DIVU: result_d = q_neg_q ? -qr_nx : qr_nx;
                        default:         result_d = r_neg_q ? -acc_nx : acc_nx;
                    endcase
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: reset clears the whole datapath too, so an abandoned operation leaves no stale result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_ADD;
            acc_q    <= '0;
            qr_q     <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q  <= state_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            qr_q     <= qr_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

endmodule
